// File: rtl/axi_line_master_pkg.sv
// Shared AXI constants and encoding helpers for the line master.
package axi_line_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding: log2 of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned nbytes);
    return 3'($clog2(nbytes));
  endfunction

endpackage

// File: rtl/axi_line_master.sv
// AXI3 line master: one INCR burst (read or write) per core request, then a one-cycle response.
// Optional macro AXI_RESP_CHECK_EN enables RRESP/BRESP/RLAST error reporting on rsp_err.
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter int unsigned WIDTH_ID  = 2,
  parameter int unsigned WIDTH_DA  = 32,
  parameter int unsigned WIDTH_AD  = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [WIDTH_AD-1:0]           req_addr,
  input  logic [BURST_LEN*WIDTH_DA-1:0] req_wdata,
  output logic                          rsp_valid,
  output logic [BURST_LEN*WIDTH_DA-1:0] rsp_rdata,
  output logic                          rsp_err,
  output logic [WIDTH_ID-1:0]           M_AXI_AWID,
  output logic [WIDTH_AD-1:0]           M_AXI_AWADDR,
  output logic [3:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [WIDTH_DA-1:0]           M_AXI_WDATA,
  output logic [WIDTH_DA/8-1:0]         M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [WIDTH_ID-1:0]           M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [WIDTH_ID-1:0]           M_AXI_ARID,
  output logic [WIDTH_AD-1:0]           M_AXI_ARADDR,
  output logic [3:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [WIDTH_ID-1:0]           M_AXI_RID,
  input  logic [WIDTH_DA-1:0]           M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int unsigned BYTES    = WIDTH_DA / 8;
  localparam int unsigned OFF_BITS = $clog2(BURST_LEN * BYTES);
  localparam int unsigned IDX_W    = $clog2(BURST_LEN);
  localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [2:0]  AX_SIZE   = axi_size(BYTES);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StRsp} state_e;

  state_e                             state_q;
  logic [WIDTH_AD-1:0]                addr_q;
  logic [BURST_LEN-1:0][WIDTH_DA-1:0] wline_q;
  logic [BURST_LEN-1:0][WIDTH_DA-1:0] rline_q;
  logic [3:0]                         beat_cnt_q;
  logic arvalid_q, awvalid_q, wvalid_q, wlast_q, rready_q, bready_q, rsp_valid_q, err_q;

  logic [IDX_W-1:0] beat_idx;
  logic             is_last;
  logic             r_err, b_err;
  logic             unused_in;

  assign beat_idx = beat_cnt_q[IDX_W-1:0];
  assign is_last  = (beat_cnt_q == LAST_BEAT);

`ifdef AXI_RESP_CHECK_EN
  assign r_err     = (M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != is_last);
  assign b_err     = (M_AXI_BRESP != AXI_RESP_OKAY);
  assign unused_in = ^{M_AXI_RID, M_AXI_BID, req_addr[OFF_BITS-1:0]};
`else
  assign r_err     = 1'b0;
  assign b_err     = 1'b0;
  assign unused_in = ^{M_AXI_RID, M_AXI_BID, M_AXI_RRESP, M_AXI_BRESP, M_AXI_RLAST,
                       req_addr[OFF_BITS-1:0]};
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= {req_addr[WIDTH_AD-1:OFF_BITS], OFF_BITS'(0)};
            wline_q    <= req_wdata;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            if (req_we) begin
              awvalid_q <= 1'b1;
              state_q   <= StAw;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
        end
        StAr: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          if (M_AXI_RVALID) begin
            rline_q[beat_idx] <= M_AXI_RDATA;
            if (r_err) err_q <= 1'b1;
            if (is_last) begin
              rready_q    <= 1'b0;
              beat_cnt_q  <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= StRsp;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end
        end
        StAw: begin
          // W only opens after AW has been accepted.
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (M_AXI_WREADY) begin
            if (is_last) begin
              wvalid_q   <= 1'b0;
              wlast_q    <= 1'b0;
              beat_cnt_q <= '0;
              bready_q   <= 1'b1;
              state_q    <= StB;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
              wlast_q    <= ((beat_cnt_q + 4'd1) == LAST_BEAT);
            end
          end
        end
        StB: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            if (b_err) err_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rline_q;
  assign rsp_err   = rsp_valid_q & err_q;

  // Burst controls are only driven while the matching VALID is up.
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = arvalid_q ? LAST_BEAT : 4'd0;
  assign M_AXI_ARSIZE  = arvalid_q ? AX_SIZE : 3'd0;
  assign M_AXI_ARBURST = arvalid_q ? AXI_BURST_INCR : 2'b00;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = awvalid_q ? LAST_BEAT : 4'd0;
  assign M_AXI_AWSIZE  = awvalid_q ? AX_SIZE : 3'd0;
  assign M_AXI_AWBURST = awvalid_q ? AXI_BURST_INCR : 2'b00;
  assign M_AXI_AWVALID = awvalid_q;

  assign M_AXI_WDATA   = wline_q[beat_idx];
  assign M_AXI_WSTRB   = wvalid_q ? '1 : '0;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: cycle-stepped slave, hand-computed expectations.
module tb_axi_line_master;

  localparam int unsigned WID = 2;
  localparam int unsigned WDA = 32;
  localparam int unsigned WAD = 32;
  localparam int unsigned BL  = 4;
`ifdef AXI_RESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 0, req_ready, req_we = 0;
  logic [WAD-1:0]  req_addr = '0;
  logic [127:0]    req_wdata = '0;
  logic            rsp_valid, rsp_err;
  logic [127:0]    rsp_rdata;
  logic [WID-1:0]  awid, arid, bid = '0, rid = '0;
  logic [WAD-1:0]  awaddr, araddr;
  logic [3:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp = '0, rresp = '0;
  logic            awvalid, awready = 1, wlast, wvalid, wready = 1, bvalid = 0, bready;
  logic            arvalid, arready = 1, rlast = 0, rvalid = 0, rready;
  logic [WDA-1:0]  wdata, rdata = '0;
  logic [WDA/8-1:0] wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  axi_line_master #(.WIDTH_ID(WID), .WIDTH_DA(WDA), .WIDTH_AD(WAD), .BURST_LEN(BL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [127:0] line,
                         input int ar_wait, input int gap, input int bad_resp,
                         input bit drop_last, input bit exp_err, input bit hold,
                         input logic [31:0] nxt_addr, input logic [127:0] nxt_wdata,
                         input int abort_at);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:4], 4'h0};
    req_valid = 1; req_we = 0; req_addr = addr;
    check_eq({tag, " req_ready idle"}, 128'(req_ready), 128'(1));
    tick();
    if (hold) begin
      req_we = 1; req_addr = nxt_addr; req_wdata = nxt_wdata;
    end else begin
      req_valid = 0; req_we = 1; req_addr = 32'hFFFF_FFF0;
    end
    check_eq({tag, " arvalid"}, 128'(arvalid), 128'(1));
    check_eq({tag, " araddr"}, 128'(araddr), 128'(exp_addr));
    check_eq({tag, " ar ctl"}, 128'({arlen, arsize, arburst, arid}), 128'({4'd3, 3'd2, 2'd1, 2'd0}));
    check_eq({tag, " req_ready busy"}, 128'(req_ready), 128'(0));
    if (ar_wait > 0) arready = 0;
    for (int i = 0; i < ar_wait; i++) begin
      rvalid = 1; // stray beat while still in AR
      tick();
      check_eq({tag, " arvalid held"}, 128'(arvalid), 128'(1));
      check_eq({tag, " araddr held"}, 128'(araddr), 128'(exp_addr));
      check_eq({tag, " rready in ar"}, 128'(rready), 128'(0));
    end
    rvalid = 0; arready = 1;
    tick();
    check_eq({tag, " arvalid drop"}, 128'(arvalid), 128'(0));
    check_eq({tag, " rready up"}, 128'(rready), 128'(1));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          rvalid = 0;
          tick();
          check_eq({tag, " rready gap"}, 128'({rready, rsp_valid}), 128'(2'b10));
        end
      end
      rvalid = 1; rdata = line[b*32 +: 32];
      rresp = (b == bad_resp) ? 2'b10 : 2'b00;
      rlast = (b == 3) && !drop_last;
      if (b == abort_at) begin
        rst_n = 0;
        #1;
        check_eq({tag, " rst rready"}, 128'(rready), 128'(0));
        check_eq({tag, " rst rsp_valid"}, 128'(rsp_valid), 128'(0));
        check_eq({tag, " rst rdata"}, rsp_rdata, 128'(0));
        rvalid = 0; rlast = 0; rresp = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        check_eq({tag, " post rst idle"}, 128'({req_ready, arvalid, rready}), 128'(3'b100));
        return;
      end
      check_eq({tag, " rready beat"}, 128'(rready), 128'(1));
      tick();
    end
    rvalid = 0; rlast = 0; rresp = 0;
    check_eq({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1));
    check_eq({tag, " rsp_rdata"}, rsp_rdata, line);
    check_eq({tag, " rsp_err"}, 128'(rsp_err), 128'(exp_err));
    check_eq({tag, " rready done"}, 128'({rready, req_ready}), 128'(0));
    tick();
    check_eq({tag, " rsp pulse"}, 128'({rsp_valid, req_ready}), 128'(2'b01));
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [127:0] line,
                          input logic [1:0] bresp_in, input bit exp_err);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:4], 4'h0};
    req_valid = 1; req_we = 1; req_addr = addr; req_wdata = line;
    check_eq({tag, " req_ready idle"}, 128'(req_ready), 128'(1));
    tick();
    req_valid = 0; req_wdata = '1; req_addr = '0;
    check_eq({tag, " awvalid"}, 128'(awvalid), 128'(1));
    check_eq({tag, " awaddr"}, 128'(awaddr), 128'(exp_addr));
    check_eq({tag, " aw ctl"}, 128'({awlen, awsize, awburst, awid}), 128'({4'd3, 3'd2, 2'd1, 2'd0}));
    check_eq({tag, " no w before aw"}, 128'(wvalid), 128'(0));
    tick();
    check_eq({tag, " awvalid drop"}, 128'(awvalid), 128'(0));
    for (int b = 0; b < 4; b++) begin
      bvalid = (b == 1); // stray B while still in W
      check_eq({tag, " w beat"}, 128'({wvalid, wlast, wstrb, bready}),
               128'({1'b1, (b == 3), 4'hF, 1'b0}));
      check_eq({tag, " wdata"}, 128'(wdata), 128'(line[b*32 +: 32]));
      tick();
    end
    bvalid = 0;
    check_eq({tag, " b wait"}, 128'({wvalid, bready, rsp_valid}), 128'(3'b010));
    bvalid = 1; bresp = bresp_in;
    tick();
    bvalid = 0; bresp = 0;
    check_eq({tag, " rsp_valid"}, 128'({rsp_valid, bready}), 128'(2'b10));
    check_eq({tag, " rsp_err"}, 128'(rsp_err), 128'(exp_err));
    tick();
    check_eq({tag, " rsp pulse"}, 128'({rsp_valid, req_ready}), 128'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] l1, l2, l3, l4, l5;
    l1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    l2 = {32'hDDDD000D, 32'hCCCC000C, 32'hBBBB000B, 32'hAAAA000A};
    l3 = {32'h0BAD0004, 32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001};
    l4 = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    l5 = {32'h55AA55AA, 32'hAA55AA55, 32'h01020304, 32'h05060708};

    tick();
    tick();
    check_eq("reset valids", 128'({arvalid, awvalid, wvalid, wlast, rready, bready}), 128'(0));
    check_eq("reset rsp", 128'({rsp_valid, rsp_err}), 128'(0));
    check_eq("reset rdata", rsp_rdata, 128'(0));
    rst_n = 1;
    tick();

    do_read("t1", 32'h100, l1, 0, 0, -1, 0, 0, 0, '0, '0, -1);
    do_write("t2", 32'h204, l2, 2'b00, 0);
    check_eq("t2 rdata held", rsp_rdata, l1);
    do_read("t3", 32'h340, l3, 5, 2, -1, 0, 0, 0, '0, '0, -1);
    do_read("t4r", 32'h1000, l4, 0, 0, -1, 0, 0, 1, 32'h2008, l5, -1);
    do_write("t4w", 32'h2008, l5, 2'b00, 0);
    do_read("t5a", 32'h500, l4, 0, 0, -1, 0, 0, 0, '0, '0, 3);
    do_read("t5b", 32'h600, l5, 0, 1, -1, 0, 0, 0, '0, '0, -1);
    do_read("t6 rresp", 32'h700, l1, 0, 0, 1, 0, ERR_EN, 0, '0, '0, -1);
    do_read("t6 rlast", 32'h710, l2, 0, 0, -1, 1, ERR_EN, 0, '0, '0, -1);
    do_write("t6 bresp", 32'h720, l3, 2'b10, ERR_EN);
    do_read("t6 clean", 32'h730, l4, 0, 0, -1, 0, 0, 0, '0, '0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
